// File: rtl/daq_pkg.sv
// Shared DAQ definitions: word width, source type codes and arbiter state encoding.
package daq_pkg;

  localparam int DAQ_WORD_BITS = 32;

  localparam logic [3:0] DAQT_NONE    = 4'h0;
  localparam logic [3:0] DAQT_ENCODER = 4'h1;
  localparam logic [3:0] DAQT_ADC     = 4'h2;
  localparam logic [3:0] DAQT_STATUS  = 4'h3;
  localparam logic [3:0] DAQT_EVENT   = 4'h4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry one extra bit so that
// full and empty differ, and the head word is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
  assign do_push = push & (~full | do_pop);

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin arbiter over NSRC DAQ sources: locks to the granted source until its
// end word or a timeout, reserving MAX_PKT FIFO slots before every grant.
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_PKT    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NSRC-1:0]                 daq_req,
  output logic [NSRC-1:0]                 daq_grant,
  input  logic [NSRC*DAQ_WORD_BITS-1:0]   daq_data,
  input  logic [NSRC-1:0]                 daq_valid,
  input  logic [NSRC-1:0]                 daq_end,
  output logic [DAQ_WORD_BITS-1:0]        out_data,
  output logic                            out_end,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [7:0]                      err_count,
  output logic                            overflow,
  input  logic                            clear_err
);

  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] RR_INIT  = SW'(NSRC - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [LW-1:0] FIFO_CAP = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PKT_RES  = LW'(MAX_PKT);

  // First requester strictly after 'last', wrapping modulo NSRC.
  function automatic logic [SW-1:0] rr_pick(input logic [NSRC-1:0] req,
                                            input logic [SW-1:0]   last);
    logic [SW-1:0] win;
    logic [SW-1:0] idx;
    win = last;
    for (int k = NSRC; k >= 1; k--) begin
      idx = SW'((int'(last) + k) % NSRC);
      win = req[idx] ? idx : win;
    end
    return win;
  endfunction

  arb_state_e              state_q, state_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [SW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NSRC-1:0]         grant_q, grant_d;
  logic [7:0]              err_q, err_d;
  logic                    ovf_q, ovf_d;

  logic [DAQ_WORD_BITS-1:0] src_word [NSRC];
  logic [NSRC-1:0]          sel_mask;
  logic [SW-1:0]            win;
  logic [LW-1:0]            level;
  logic [DAQ_WORD_BITS:0]   fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_drop;
  logic                     can_grant;
  logic                     push;
  logic                     stray;
  logic                     tmo_hit;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src_word[g] = daq_data[g*DAQ_WORD_BITS +: DAQ_WORD_BITS];
  end

  // One-hot view of the locked source, used to spot writes from anyone else.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel_mask[i] = (sel_q == SW'(i));
    end
  end

  assign win       = rr_pick(daq_req, rr_ptr_q);
  assign can_grant = (|daq_req) && ((FIFO_CAP - level) >= PKT_RES);
  assign fifo_drop = push & fifo_full & ~(out_ready & ~fifo_empty);

  // Arbitration and lock next-state.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    tmo_d    = tmo_q;
    grant_d  = '0;
    push     = 1'b0;
    stray    = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        stray = |daq_valid;
        if (can_grant) begin
          grant_d[win] = 1'b1;
          sel_d        = win;
          rr_ptr_d     = win;
          tmo_d        = TMO_LOAD;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stray = |(daq_valid & ~sel_mask);
        if (daq_valid[sel_q]) begin
          push  = 1'b1;
          tmo_d = TMO_LOAD;
          if (daq_end[sel_q]) begin
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end else if (tmo_q <= TMO_ONE) begin
          tmo_d   = '0;
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Error counter and sticky overflow; clear wins over a same-cycle event.
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clear_err) begin
      err_d = 8'd0;
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | fifo_drop;
      if ((stray | tmo_hit) && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= RR_INIT;
      tmo_q    <= '0;
      grant_q  <= '0;
      err_q    <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      tmo_q    <= tmo_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (DAQ_WORD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({daq_end[sel_q], src_word[sel_q]}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign daq_grant  = grant_q;
  assign out_data   = fifo_rdata[DAQ_WORD_BITS-1:0];
  assign out_end    = fifo_rdata[DAQ_WORD_BITS];
  assign out_valid  = ~fifo_empty;
  assign fifo_level = level;
  assign err_count  = err_q;
  assign overflow   = ovf_q;

endmodule
